// File: rtl/uartrx2axis.sv
// UART receiver that parses ASCII hex tokens into words and streams them out on AXI-stream.
// A newline closes a line: the last word of that line carries tlast.
module uartrx2axis #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_ASIZE = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  uart_rx,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  tlast,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam int DEPTH = 1 << FIFO_ASIZE;
    localparam logic [FIFO_ASIZE-1:0] PTR_ONE = FIFO_ASIZE'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHI
    } rx_state_t;

    // Returns {is_hex, nibble} for an ASCII character.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    logic rx_meta, rx_sync, rx_prev;

    // Two-stage synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bitcnt, bitcnt_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            byte_valid, byte_valid_nxt;
    logic            frame_err_nxt;

    // RX state and bit timing registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= S_IDLE;
            cnt        <= CNT_ZERO;
            bitcnt     <= 3'd0;
            shreg      <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // RX next-state: start bit checked mid-bit, then data and stop sampled one bit period apart.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bitcnt_nxt     = bitcnt;
        shreg_nxt      = shreg;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_nxt = S_START;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt    = CNT_ZERO;
                    bitcnt_nxt = 3'd0;
                    if (!rx_sync) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt   = CNT_ZERO;
                    shreg_nxt = {rx_sync, shreg[7:1]};
                    if (bitcnt == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bitcnt_nxt = bitcnt + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = CNT_ZERO;
                    if (rx_sync) begin
                        byte_valid_nxt = 1'b1;
                        state_nxt      = S_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_WAITHI;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_WAITHI: begin
                if (rx_sync) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAITHI;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    logic [4:0]            dec;
    logic [DATA_WIDTH-1:0] acc, hold;
    logic [7:0]            digcnt;
    logic                  hold_v;
    logic                  push_en, pend_en;
    logic                  push_last, pend_last;
    logic [DATA_WIDTH-1:0] push_word, pend_word;

    assign dec = hex_decode(shreg);

    // Token parser; a completed word waits in hold until the next token or newline fixes its tlast.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc       <= '0;
            hold      <= '0;
            digcnt    <= 8'd0;
            hold_v    <= 1'b0;
            push_en   <= 1'b0;
            push_last <= 1'b0;
            push_word <= '0;
            pend_en   <= 1'b0;
            pend_last <= 1'b0;
            pend_word <= '0;
        end else begin
            push_en   <= pend_en;
            push_last <= pend_last;
            push_word <= pend_word;
            pend_en   <= 1'b0;
            if (byte_valid) begin
                if (dec[4]) begin
                    acc <= (acc << 4) | DATA_WIDTH'(dec[3:0]);
                    if (digcnt != 8'hFF) begin
                        digcnt <= digcnt + 8'd1;
                    end
                end else begin
                    case (shreg)
                        8'h20, 8'h09, 8'h2C: begin
                            if (digcnt != 8'd0) begin
                                if (hold_v) begin
                                    push_en   <= 1'b1;
                                    push_word <= hold;
                                    push_last <= 1'b0;
                                end
                                hold   <= acc;
                                hold_v <= 1'b1;
                                acc    <= '0;
                                digcnt <= 8'd0;
                            end
                        end
                        8'h0A: begin
                            if (digcnt != 8'd0) begin
                                push_en <= 1'b1;
                                if (hold_v) begin
                                    push_word <= hold;
                                    push_last <= 1'b0;
                                    pend_en   <= 1'b1;
                                    pend_word <= acc;
                                    pend_last <= 1'b1;
                                end else begin
                                    push_word <= acc;
                                    push_last <= 1'b1;
                                end
                                hold_v <= 1'b0;
                                acc    <= '0;
                                digcnt <= 8'd0;
                            end else if (hold_v) begin
                                push_en   <= 1'b1;
                                push_word <= hold;
                                push_last <= 1'b1;
                                hold_v    <= 1'b0;
                            end
                        end
                        8'h0D: begin
                        end
                        default: begin
                            acc    <= '0;
                            digcnt <= 8'd0;
                        end
                    endcase
                end
            end
        end
    end

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [FIFO_ASIZE-1:0] wpt, rpt, wpt_nxt, rpt_nxt;
    logic                  full, pop, wr_en, ovf_nxt, out_nxt;

    // The output register mirrors mem[rpt]; rpt only advances on a beat, so it counts toward capacity.
    assign full    = ((wpt + PTR_ONE) == rpt);
    assign pop     = tvalid & tready;
    assign wr_en   = push_en & (~full | pop);
    assign ovf_nxt = push_en & full & ~pop;
    assign wpt_nxt = wr_en ? (wpt + PTR_ONE) : wpt;
    assign rpt_nxt = pop ? (rpt + PTR_ONE) : rpt;
    assign out_nxt = (rpt_nxt != wpt_nxt);

    // FIFO storage.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wpt] <= {push_last, push_word};
        end
    end

    // Pointers and first-word-fall-through output register with write bypass.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wpt      <= '0;
            rpt      <= '0;
            tvalid   <= 1'b0;
            tlast    <= 1'b0;
            tdata    <= '0;
            overflow <= 1'b0;
        end else begin
            wpt      <= wpt_nxt;
            rpt      <= rpt_nxt;
            overflow <= ovf_nxt;
            tvalid   <= out_nxt;
            if (out_nxt) begin
                if (wr_en && (wpt == rpt_nxt)) begin
                    {tlast, tdata} <= {push_last, push_word};
                end else begin
                    {tlast, tdata} <= mem[rpt_nxt];
                end
            end
        end
    end
endmodule

// File: tb/tb_uartrx2axis.sv
// Scoreboard bench for uartrx2axis: a text-level model predicts beats, a monitor checks them.
module tb_uartrx2axis;
    localparam int CLK_DIV = 8;
    localparam int DW      = 32;
    localparam int ASIZE   = 2;
    localparam int CAP     = (1 << ASIZE) - 1;

    logic aclk, areset, uart_rx, tvalid, tready, tlast, frame_err, overflow;
    logic [DW-1:0] tdata;

    uartrx2axis #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW), .FIFO_ASIZE(ASIZE)) dut (
        .aclk(aclk), .areset(areset), .uart_rx(uart_rx), .tvalid(tvalid), .tready(tready),
        .tlast(tlast), .tdata(tdata), .frame_err(frame_err), .overflow(overflow)
    );

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    beat_t exp_q[$];
    logic [7:0] txt[$];

    int checks = 0, errors = 0;
    int cycle = 0, byte_start = 0, beat_cycle = 0;
    int frame_cnt = 0, ovf_cnt = 0, model_total = 0;
    bit rand_ready = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial forever begin
        @(posedge aclk);
        cycle = cycle + 1;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rand_ready) tready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard and checks stall stability.
    initial begin
        bit stall;
        logic [DW-1:0] sd;
        logic sl;
        beat_t e;
        stall = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall = 0;
            end else begin
                if (frame_err) frame_cnt++;
                if (overflow) ovf_cnt++;
                if (stall) begin
                    checks++;
                    if (!tvalid || tdata !== sd || tlast !== sl) begin
                        errors++;
                        $display("FAIL stall_stable: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b", tvalid, tdata, tlast, sd, sl);
                    end
                end
                stall = tvalid && !tready;
                sd = tdata;
                sl = tlast;
                if (tvalid && tready) begin
                    beat_cycle = cycle;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got d=%0h l=%0b, expected no beat", tdata, tlast);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", {32'd0, tdata}, {32'd0, e.data});
                        chk("beat_last", {63'd0, tlast}, {63'd0, e.last});
                    end
                end
            end
        end
    end

    function automatic bit hexval(input logic [7:0] c, output logic [3:0] v);
        v = 4'd0;
        if (c >= "0" && c <= "9") begin v = 4'(c - 8'd48); return 1'b1; end
        if (c >= "A" && c <= "F") begin v = 4'(c - 8'd55); return 1'b1; end
        if (c >= "a" && c <= "f") begin v = 4'(c - 8'd87); return 1'b1; end
        return 1'b0;
    endfunction

    // Text-level model: tokens of a line are collected, the line's final word gets tlast.
    task automatic model_txt(input int keep);
        logic [DW-1:0] cur;
        logic [3:0] v;
        bit has;
        beat_t b;
        beat_t words[$];
        cur = '0;
        has = 0;
        model_total = 0;
        foreach (txt[i]) begin
            if (hexval(txt[i], v)) begin
                cur = (cur * 16) + DW'(v);
                has = 1;
            end else if (txt[i] == " " || txt[i] == 8'h09 || txt[i] == ",") begin
                if (has) begin b.data = cur; b.last = 0; words.push_back(b); end
                cur = '0;
                has = 0;
            end else if (txt[i] == 8'h0A) begin
                if (has) begin b.data = cur; b.last = 0; words.push_back(b); end
                cur = '0;
                has = 0;
                if (words.size() > 0) words[words.size()-1].last = 1;
                foreach (words[k]) begin
                    if (model_total < keep) exp_q.push_back(words[k]);
                    model_total++;
                end
                words.delete();
            end else if (txt[i] != 8'h0D) begin
                cur = '0;
                has = 0;
            end
        end
    endtask

    task automatic load(input string s);
        txt.delete();
        for (int i = 0; i < s.len(); i++) txt.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(posedge aclk);
        #1;
        byte_start = cycle;
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (CLK_DIV) @(posedge aclk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (2) @(posedge aclk);
    endtask

    task automatic send_txt();
        foreach (txt[i]) send_byte(txt[i], 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (20) @(posedge aclk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_tvalid"}, {63'd0, tvalid}, 64'd0);
        chk({name, "_tlast"}, {63'd0, tlast}, 64'd0);
        chk({name, "_tdata"}, {32'd0, tdata}, 64'd0);
        chk({name, "_frame_err"}, {63'd0, frame_err}, 64'd0);
        chk({name, "_overflow"}, {63'd0, overflow}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string hexs, bads;
        int f0, o0, r, ntok, nd, sel;
        hexs = "0123456789abcdefABCDEF";
        bads = "GxZ-.!";
        uart_rx = 1'b1;
        tready = 1'b0;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk_outputs_zero("reset");
        areset = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        tready = 1'b1;

        load("1234ABCD\n");
        model_txt(1000);
        send_txt();
        drain("single");
        chk("latency_ok", {63'd0, (beat_cycle >= byte_start) && (beat_cycle - byte_start <= 10 * CLK_DIV + 4)}, 64'd1);

        load("1a 2B,3 \r\n\n");
        model_txt(1000);
        send_txt();
        drain("separators");

        load("123456789\n12G34\n");
        model_txt(1000);
        send_txt();
        drain("truncate_invalid");

        f0 = frame_cnt;
        send_byte(8'h41, 1'b0);
        repeat (10) @(posedge aclk);
        #1;
        chk("frame_err_cycles", 64'(frame_cnt - f0), 64'd1);
        uart_rx = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        uart_rx = 1'b1;
        repeat (4 * CLK_DIV) @(posedge aclk);
        #1;
        chk("glitch_no_frame_err", 64'(frame_cnt - f0), 64'd1);
        load("7\n");
        model_txt(1000);
        send_txt();
        drain("after_glitch");

        tready = 1'b0;
        o0 = ovf_cnt;
        load("1 2 3 4 5 6\n");
        model_txt(CAP);
        send_txt();
        repeat (10) @(posedge aclk);
        #1;
        chk("overflow_pulses", 64'(ovf_cnt - o0), 64'(model_total - CAP));
        chk("full_tvalid", {63'd0, tvalid}, 64'd1);
        tready = 1'b1;
        drain("overflow");
        chk("empty_tvalid", {63'd0, tvalid}, 64'd0);

        load("AB C");
        send_txt();
        repeat (5) @(posedge aclk);
        #1;
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk_outputs_zero("midline_reset");
        exp_q.delete();
        areset = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        load("EF\n");
        model_txt(1000);
        send_txt();
        drain("after_reset");

        f0 = frame_cnt;
        o0 = ovf_cnt;
        rand_ready = 1;
        for (int ln = 0; ln < 12; ln++) begin
            txt.delete();
            r = $urandom_range(0, 9);
            if (r == 1) txt.push_back(8'h0D);
            if (r > 1) begin
                ntok = $urandom_range(1, 4);
                for (int t = 0; t < ntok; t++) begin
                    nd = $urandom_range(1, 10);
                    for (int d = 0; d < nd; d++) txt.push_back(hexs[$urandom_range(0, 21)]);
                    if ($urandom_range(0, 5) == 0) begin
                        txt.push_back(bads[$urandom_range(0, 5)]);
                        nd = $urandom_range(0, 3);
                        for (int d = 0; d < nd; d++) txt.push_back(hexs[$urandom_range(0, 21)]);
                    end
                    sel = $urandom_range(0, 4);
                    if (t < ntok - 1 || $urandom_range(0, 1) == 1) begin
                        case (sel)
                            0: txt.push_back(8'h20);
                            1: txt.push_back(8'h09);
                            2: txt.push_back(8'h2C);
                            3: begin txt.push_back(8'h20); txt.push_back(8'h0D); end
                            default: begin txt.push_back(8'h20); txt.push_back(8'h20); end
                        endcase
                    end
                end
            end
            txt.push_back(8'h0A);
            model_txt(1000);
            send_txt();
        end
        rand_ready = 0;
        @(posedge aclk);
        #1;
        tready = 1'b1;
        drain("random");
        chk("random_no_overflow", 64'(ovf_cnt - o0), 64'd0);
        chk("random_no_frame_err", 64'(frame_cnt - f0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uartrx2axis.md
Name:
uartrx2axis

Overview:
- UART receiver that parses ASCII hex text into words and emits them on an AXI-stream master.
- It is the input-side counterpart of the AXI-stream-to-UART hex printer used in the UART read/write example. A host terminal types lines such as "1234ABCD 5\n".
- Each hex token becomes one beat. A newline sets tlast on the last word of the line.
- Words are buffered in an internal FIFO, so downstream backpressure does not stall reception until the FIFO is full.

Parameters:
- CLK_DIV, 434: aclk cycles per UART bit. Must be at least 4.
- DATA_WIDTH, 32: tdata width. Each token keeps its last ceil(DATA_WIDTH/4) hex digits, truncated to DATA_WIDTH bits.
- FIFO_ASIZE, 8: FIFO address bits. Total stored-word capacity is 2^FIFO_ASIZE - 1, output register included.

Ports:
- aclk, input, 1: clock.
- areset, input, 1: asynchronous, active-high reset.
- uart_rx, input, 1: asynchronous serial line, idle high.
- tvalid, output, 1: AXI-stream master valid.
- tready, input, 1: AXI-stream ready.
- tlast, output, 1: last word of a text line.
- tdata, output, DATA_WIDTH: parsed word.
- frame_err, output, 1: one-cycle pulse, stop bit sampled low.
- overflow, output, 1: one-cycle pulse, word dropped because the FIFO is full.

Behaviour:
- Reset:
  - tvalid=0, tlast=0, tdata=0, frame_err=0, overflow=0.
  - FIFO empty, parser accumulator, digit count and hold register cleared, RX FSM in IDLE.
  - Reset mid-byte or mid-line discards everything received so far. Reception restarts on the next falling edge after release.
- Input sync: uart_rx passes through a 2-FF synchronizer, reset value 1. All decoding uses the synchronized signal.
- RX FSM:
  - IDLE: on a synced 1->0 transition, go to START with counter=0.
  - START: at count CLK_DIV/2-1, sample. Low: go to DATA. High: glitch, back to IDLE, no output.
  - DATA: sample every CLK_DIV cycles. 8 bits, LSB first, then STOP.
  - STOP: sample after CLK_DIV cycles.
    - High: byte valid for one cycle.
    - Low: frame_err pulses for one cycle, the byte is discarded, and the FSM waits in WAITHI until the line is high, then IDLE.
- Parser (acts on each valid byte; bytes arrive at least 10*CLK_DIV cycles apart):
  - Hex digit '0'-'9', 'A'-'F', 'a'-'f': acc <= {acc, nibble} truncated to DATA_WIDTH; digcnt++ (saturating).
  - Space, tab or ',': if digcnt>0, complete the token.
  - '\n': if digcnt>0, complete the token. Then, if the hold register is occupied, push it with tlast=1 and empty the hold.
  - '\r': ignored.
  - Any other byte: clear acc and digcnt; the hold register is unaffected.
  - Completing a token: if the hold register is occupied, push the held word with tlast=0. Then load the hold register with acc, clear acc and digcnt.
  - A word is therefore pushed only once the next token or a newline decides its tlast. A trailing separator before '\n' still yields tlast=1 on the final word.
  - Empty lines produce nothing.
  - Up to two pushes may result from one byte; they occur on consecutive cycles.
- FIFO:
  - Synchronous-RAM ring with rpt/wpt pointers and a first-word-fall-through output register.
  - Push when full: the word is dropped, overflow pulses for one cycle, and parser state continues normally.
  - A push and a pop in the same cycle are both honoured.
- AXI-stream:
  - Beat transfers when tvalid & tready.
  - While tvalid=1 & tready=0, tdata and tlast stay stable.
  - tvalid does not depend on tready.
  - With the FIFO empty and tready=1, a word pushed by a byte appears on tvalid no later than 4 cycles after that byte's stop-bit sample.
- Arithmetic: counters wrap only as stated; pointers wrap modulo 2^FIFO_ASIZE.

Test Plan:
- CLK_DIV=8, DATA_WIDTH=32, tready=1, send "1234ABCD\n": one beat 0x1234ABCD, tlast=1, within 4 cycles of the '\n' stop sample.
- Send "1a 2B,3 \r\n\n": beats 0x1A tlast=0, 0x2B tlast=0, 0x3 tlast=1. The second '\n' yields no beat.
- Send "123456789\n" then "12G34\n": beat 0x23456789 tlast=1 (truncation), then 0x34 tlast=1 (G clears the partial token).
- Send a byte with stop bit=0: frame_err high exactly 1 cycle, no beat. Drive a 2-cycle low glitch on idle uart_rx: no output, no frame_err. Then "7\n": beat 0x7 tlast=1.
- FIFO_ASIZE=2, tready=0, send "1 2 3 4 5 6\n": overflow pulses 3 times. Raise tready: beats 0x1, 0x2, 0x3, all tlast=0, then tvalid=0.
- Assert areset mid-way through "AB CD\n" (after 'C' is received): all outputs 0. After release, "EF\n" gives a single beat 0xEF tlast=1.
